// File: rtl/cdb_arbiter_pkg.sv
// Shared types and system-level sizes for the common data bus arbiter.
// CDB_PACKET is the bundle broadcast to reservation stations and the ROB.
package cdb_arbiter_pkg;

   localparam int ROB_TAG_BITS = 5;
   localparam int CDB_NUM_REQ  = 4;
   localparam int CDB_CNT_W    = 16;

   typedef struct packed {
      logic                    valid;
      logic [31:0]             value;
      logic [ROB_TAG_BITS-1:0] tag;
   } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin picker: a doubled-vector priority encoder.
// The request vector is rotated so the pointer lands at bit 0, then the lowest set bit wins.
module rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [IDX_W-1:0]     off;
   logic [IDX_W:0]       sum;

   // Rotate, find the first requester at or after ptr, map back to an index.
   always_comb begin
      dbl = {req, req} >> ptr;
      rot = dbl[NUM_REQ-1:0];
      off = '0;
      any = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = IDX_W'(i);
            any = 1'b1;
         end
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= N_W) begin
         sum = sum - N_W;
      end
      grant_idx    = sum[IDX_W-1:0];
      grant_onehot = '0;
      if (any) begin
         grant_onehot[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one registered broadcast per cycle, round-robin fair.
// Losing units are told to hold their packet through req_busy.
import cdb_arbiter_pkg::*;

module cdb_arbiter #(
   parameter int NUM_REQ = CDB_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ),
   parameter int CNT_W   = CDB_CNT_W
) (
   input  logic               clock,
   input  logic               reset,
   input  CDB_PACKET          req_pkt [NUM_REQ],
   input  logic               flush,
   output logic [NUM_REQ-1:0] req_busy,
   output CDB_PACKET          cdb_out,
   output logic [IDX_W-1:0]   grant_idx,
   output logic [CNT_W-1:0]   conflict_cnt
);

   localparam logic [IDX_W-1:0]   LAST = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

   logic [NUM_REQ-1:0] valid;
   logic [NUM_REQ-1:0] win_oh;
   logic [IDX_W-1:0]   win;
   logic [IDX_W-1:0]   ptr_nxt;
   logic [IDX_W-1:0]   rr_ptr;
   logic               any;
   logic               grant;
   logic               multi;

   // Gather the valid bits that the picker arbitrates over.
   always_comb begin
      valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         valid[i] = req_pkt[i].valid;
      end
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req          (valid),
      .ptr          (rr_ptr),
      .grant_onehot (win_oh),
      .grant_idx    (win),
      .any          (any)
   );

   // Grant, hold-back and contention decode; flush squashes everything.
   always_comb begin
      grant    = any & ~flush;
      multi    = |(valid & (valid - ONE));
      ptr_nxt  = (win == LAST) ? '0 : win + IDX_W'(1);
      req_busy = (reset | flush) ? '0 : (valid & ~win_oh);
   end

   // Broadcast register and round-robin pointer.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cdb_out   <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else if (grant) begin
         cdb_out       <= req_pkt[win];
         cdb_out.valid <= 1'b1;
         grant_idx     <= win;
         rr_ptr        <= ptr_nxt;
      end else begin
         cdb_out.valid <= 1'b0;
      end
   end

   // Saturating count of contended, non-flushed cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         conflict_cnt <= '0;
      end else if (!flush && multi && conflict_cnt != '1) begin
         conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic
// checked against a search-order reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic         clock = 1'b0;
   logic         reset;
   logic         flush;
   CDB_PACKET    req [N];
   logic [N-1:0] req_busy;
   CDB_PACKET    cdb_out;
   logic [1:0]   grant_idx;
   logic [15:0]  conflict_cnt;

   cdb_arbiter #(.NUM_REQ(N)) dut (
      .clock        (clock),
      .reset        (reset),
      .req_pkt      (req),
      .flush        (flush),
      .req_busy     (req_busy),
      .cdb_out      (cdb_out),
      .grant_idx    (grant_idx),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int           m_ptr;
   int           m_gidx;
   int           m_cnt;
   CDB_PACKET    m_cdb;
   logic [N-1:0] m_busy;
   int           wait_c [N];

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_ptr  = 0;
      m_gidx = 0;
      m_cnt  = 0;
      m_cdb  = '0;
      m_busy = '0;
      for (int i = 0; i < N; i++) wait_c[i] = 0;
   endtask

   function automatic int m_win();
      int j;
      if (flush) return -1;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (req[j].valid) return j;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input logic v,
                          input logic [31:0] val, input logic [4:0] tg);
      req[i].valid = v;
      req[i].value = val;
      req[i].tag   = tg;
   endtask

   task automatic clr_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h0, 5'h0);
   endtask

   // One clock: check busy mid-cycle, advance model, check registers.
   task automatic step(input string tag);
      int w;
      int nv;
      w  = m_win();
      nv = 0;
      for (int i = 0; i < N; i++) if (req[i].valid) nv++;
      m_busy = '0;
      if (w >= 0) begin
         for (int i = 0; i < N; i++) m_busy[i] = req[i].valid && (i != w);
      end
      @(negedge clock);
      chk({tag, ".busy"}, 64'(req_busy), 64'(m_busy));
      for (int i = 0; i < N; i++) begin
         if (req_busy[i]) begin
            wait_c[i]++;
            chk({tag, ".fair"}, 64'(wait_c[i] <= N - 1), 64'd1);
         end else begin
            wait_c[i] = 0;
         end
      end
      if (w >= 0) begin
         m_cdb       = req[w];
         m_cdb.valid = 1'b1;
         m_gidx      = w;
         m_ptr       = (w + 1) % N;
      end else begin
         m_cdb.valid = 1'b0;
      end
      if (!flush && nv >= 2 && m_cnt < 65535) m_cnt++;
      @(posedge clock);
      #1;
      chk({tag, ".cdb"}, 64'(cdb_out), 64'(m_cdb));
      chk({tag, ".gidx"}, 64'(grant_idx), 64'(m_gidx));
      chk({tag, ".cnt"}, 64'(conflict_cnt), 64'(m_cnt));
      chk({tag, ".ptr"}, 64'(dut.rr_ptr), 64'(m_ptr));
   endtask

   task automatic rand_traffic(input int n);
      for (int c = 0; c < n; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_busy[i]) begin
               req[i].valid = ($urandom_range(0, 99) < 55);
               req[i].value = $urandom;
               req[i].tag   = 5'($urandom);
            end
         end
         flush = ($urandom_range(0, 15) == 0);
         step("rnd");
      end
      flush = 1'b0;
   endtask

   int p0;
   int c0;

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      clr_all();
      m_reset();
      set_req(2, 1'b1, 32'h55, 5'd2);
      #12;
      chk("rst.cdb", 64'(cdb_out), 64'd0);
      chk("rst.gidx", 64'(grant_idx), 64'd0);
      chk("rst.cnt", 64'(conflict_cnt), 64'd0);
      chk("rst.busy", 64'(req_busy), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      clr_all();
      @(posedge clock);
      #1;

      rand_traffic(300);

      // asynchronous reset in the middle of a cycle
      clr_all();
      set_req(2, 1'b1, 32'h77, 5'd6);
      #3;
      reset = 1'b1;
      #1;
      chk("mrst.cdb", 64'(cdb_out), 64'd0);
      chk("mrst.gidx", 64'(grant_idx), 64'd0);
      chk("mrst.cnt", 64'(conflict_cnt), 64'd0);
      chk("mrst.busy", 64'(req_busy), 64'd0);
      chk("mrst.ptr", 64'(dut.rr_ptr), 64'd0);
      m_reset();
      @(negedge clock);
      reset = 1'b0;
      clr_all();
      @(posedge clock);
      #1;

      set_req(0, 1'b1, 32'h8, 5'd3);
      step("u0");
      chk("u0.pkt", 64'(cdb_out), {26'd0, 1'b1, 32'h8, 5'd3});
      chk("u0.idx", 64'(grant_idx), 64'd0);
      clr_all();
      set_req(3, 1'b1, 32'h3, 5'd9);
      step("pre0");
      clr_all();

      // full contention from rr_ptr = 0
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h100 + i, 5'(i + 1));
      c0 = m_cnt;
      for (int k = 0; k < 5; k++) begin
         step("fc");
         chk("fc.tag", 64'(cdb_out.tag), 64'((k % 4) + 1));
         chk("fc.inc", 64'(conflict_cnt), 64'(c0 + k + 1));
      end

      // hold and wrap from rr_ptr = 3
      clr_all();
      set_req(2, 1'b1, 32'h22, 5'd2);
      step("pre3");
      clr_all();
      set_req(1, 1'b1, 32'h11, 5'd11);
      set_req(3, 1'b1, 32'h33, 5'd13);
      #1;
      chk("hw.busy", 64'(req_busy), 64'b0010);
      step("hw1");
      chk("hw1.idx", 64'(grant_idx), 64'd3);
      req[3].valid = 1'b0;
      #1;
      chk("hw.busy2", 64'(req_busy), 64'd0);
      step("hw2");
      chk("hw2.idx", 64'(grant_idx), 64'd1);
      chk("hw2.ptr", 64'(dut.rr_ptr), 64'd2);

      // flush squashes a contended cycle
      clr_all();
      set_req(0, 1'b1, 32'hA0, 5'd1);
      set_req(2, 1'b1, 32'hA2, 5'd2);
      flush = 1'b1;
      p0 = m_ptr;
      c0 = m_cnt;
      #1;
      chk("fl.busy", 64'(req_busy), 64'd0);
      step("fl");
      chk("fl.valid", 64'(cdb_out.valid), 64'd0);
      chk("fl.ptr", 64'(dut.rr_ptr), 64'(p0));
      chk("fl.cnt", 64'(conflict_cnt), 64'(c0));
      flush = 1'b0;
      clr_all();

      // request, idle, request from unit 1
      set_req(1, 1'b1, 32'hABCD, 5'd7);
      step("ig1");
      chk("ig1.v", 64'(cdb_out.valid), 64'd1);
      clr_all();
      step("ig2");
      chk("ig2.v", 64'(cdb_out.valid), 64'd0);
      chk("ig2.val", 64'(cdb_out.value), 64'hABCD);
      chk("ig2.tag", 64'(cdb_out.tag), 64'd7);
      set_req(1, 1'b1, 32'h1234, 5'd9);
      step("ig3");
      chk("ig3.v", 64'(cdb_out.valid), 64'd1);
      chk("ig3.tag", 64'(cdb_out.tag), 64'd9);
      clr_all();

      rand_traffic(2000);

      // saturation of the conflict counter
      reset = 1'b1;
      #1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'h5A, 5'd1);
      @(negedge clock);
      reset = 1'b0;
      repeat (65534) @(posedge clock);
      #1;
      chk("sat.fffe", 64'(conflict_cnt), 64'hFFFE);
      @(posedge clock);
      #1;
      chk("sat.ffff", 64'(conflict_cnt), 64'hFFFF);
      repeat (4) @(posedge clock);
      #1;
      chk("sat.hold", 64'(conflict_cnt), 64'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
